mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multiply/divide unit in the EX stage, beside the ALU, fed by the same forwarded operand buses.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations into the architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Exports start/busy to the hazard unit, which stalls any MD-class instruction in D while start||busy. The result is muxed with the ALU result into the EX/MEM register.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (≥1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- operand1  input  32  rs value (dividend / multiplicand / MT source).
- operand2  input  32  rt value (divisor / multiplier).
- operation  input  4  encoding: 0 NOOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NOOP.
- cancel  input  1  the EX instruction is being flushed by an exception or interrupt; suppresses every state change this cycle.
- start  output  1  combinational; high when operation is 1-4, busy=0 and cancel=0.
- busy  output  1  registered; operation in flight.
- result  output  32  combinational. HI when MFHI, LO when MFLO, else 0.

Behaviour:
- Reset (async): HI=0, LO=0, busy=0, counter=0, and any pending result is discarded. Reset mid-operation aborts the operation, and HI/LO read 0 afterwards.
- Start cycle, on the clock edge where start=1:
  - Latch the operands and the op.
  - busy←1; counter←MULT_CYCLES or DIV_CYCLES.
  - HI/LO do not change on this edge.
- Busy phase:
  - Each edge with busy=1 decrements counter.
  - On the edge where counter==1: busy←0, and HI/LO are written with the result.
  - Observable timing: with start at edge E0, busy is high for exactly N cycles (edges E1..EN). New HI/LO are visible after EN, and busy reads 0 in that same cycle.
- Internal structure is free (single-cycle compute held in a register, or an iterative datapath), provided the HI/LO values and busy timing match this spec exactly.
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV:
  - LO = quotient truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient → LO, remainder → HI.
- Divide by zero (DIV/DIVU with operand2==0): busy timing is unchanged, and HI/LO keep their old values.
- MTHI/MTLO: write operand1 into HI/LO on the edge, only when busy=0 and cancel=0.
- MFHI/MFLO: pure read with no state change. Reads while busy=1 return the old HI/LO. The hazard unit prevents such reads; the block does not interlock.
- Any op 1-4 or 7-8 arriving while busy=1 is ignored: no restart, no write, and the in-flight operation continues.
- cancel=1: start=0, and no MT write happens. cancel does not abort an operation already in flight.
- An operation is never re-triggered by a held operation value: after completion, a new start requires busy=0. The hazard unit ensures a new instruction is present.
- No overflow or exception output. MD ops never trap.

Test Plan:
- MULT: operand1=0xFFFFFFFE (-2), operand2=0x00000003 →
  - start pulses 1 cycle; busy high 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MFHI/MFLO return these values.
- MULTU vs DIV:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after exactly 10 busy cycles.
  - DIVU 7/2 → LO=3, HI=1.
- Edge cases:
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIV 5/0 with HI/LO preset by MTHI 0x11 and MTLO 0x22 → busy for 10 cycles, then HI=0x11, LO=0x22.
- Busy interference:
  - MTLO 0x55 issued while busy → ignored; LO equals the product afterwards.
  - A second MULT issued during busy does not extend busy.
- cancel=1 with operation=MULT → start=0, busy stays 0, HI/LO unchanged. cancel=1 with MTHI → HI unchanged.
- Reset asserted asynchronously at busy cycle 3 of a DIV → busy=0, HI=LO=0 immediately, with no later write.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO with MFHI/MFLO/MTHI/MTLO access
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [3:0]  operation,
    input  logic        cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] result
);
    typedef enum logic [3:0] {
        OP_NOOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } op_t;
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [CW-1:0] cnt;
    logic [31:0] hi, lo, a_q, b_q;
    op_t op_q;
    logic is_mul, sgn, neg_a, neg_b;
    logic [63:0] ax, bx, prod;
    logic [31:0] ua, ub, uq, ur, quo, rem;
    // Result is computed from the latched operands and only committed on the last busy edge
    always_comb begin
        is_mul = op_q == OP_MULT || op_q == OP_MULTU;
        sgn = op_q == OP_MULT || op_q == OP_DIV;
        neg_a = sgn & a_q[31];
        neg_b = sgn & b_q[31];
        ax = {{32{neg_a}}, a_q};
        bx = {{32{neg_b}}, b_q};
        prod = ax * bx;
        ua = neg_a ? -a_q : a_q;
        ub = neg_b ? -b_q : b_q;
        uq = ub == '0 ? '0 : ua / ub;
        ur = ub == '0 ? '0 : ua % ub;
        quo = neg_a ^ neg_b ? -uq : uq;
        rem = neg_a ? -ur : ur;
        start = operation >= 4'd1 && operation <= 4'd4 && !busy && !cancel;
        result = op_t'(operation) == OP_MFHI ? hi : op_t'(operation) == OP_MFLO ? lo : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            busy <= 1'b0;
            cnt <= '0;
            op_q <= OP_NOOP;
            a_q <= '0;
            b_q <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt <= operation <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            op_q <= op_t'(operation);
            a_q <= operand1;
            b_q <= operand2;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (is_mul) {hi, lo} <= prod;
                else if (b_q != '0) {hi, lo} <= {rem, quo};
            end
        end else if (!cancel) begin
            if (op_t'(operation) == OP_MTHI) hi <= operand1;
            if (op_t'(operation) == OP_MTLO) lo <= operand1;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random stimulus checked against a plain-arithmetic HI/LO model
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] operand1 = '0, operand2 = '0;
    logic [3:0]  operation = '0;
    logic        cancel = 1'b0;
    logic        start, busy;
    logic [31:0] result;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    logic        m_pv;
    int          m_rem;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .operand1(operand1), .operand2(operand2),
        .operation(operation), .cancel(cancel), .start(start), .busy(busy), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: final HI/LO are computed at issue with 64-bit arithmetic and released when the busy count runs out
    always @(posedge clk or posedge reset) begin
        longint sa, sb, q, r;
        longint unsigned ua, ubv;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pv = 1'b0; m_pend = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pv) {m_hi, m_lo} = m_pend;
        end else if (!cancel) begin
            sa = longint'($signed(operand1));
            sb = longint'($signed(operand2));
            ua = {32'b0, operand1};
            ubv = {32'b0, operand2};
            case (operation)
                4'd1: begin m_pend = sa * sb; m_pv = 1'b1; m_rem = MC; end
                4'd2: begin m_pend = ua * ubv; m_pv = 1'b1; m_rem = MC; end
                4'd3: begin
                    m_rem = DC;
                    m_pv = operand2 != 0;
                    if (m_pv) begin
                        q = sa / sb;
                        r = sa % sb;
                        m_pend = {r[31:0], q[31:0]};
                    end
                end
                4'd4: begin
                    m_rem = DC;
                    m_pv = operand2 != 0;
                    if (m_pv) m_pend = {32'(ua % ubv), 32'(ua / ubv)};
                end
                4'd7: m_hi = operand1;
                4'd8: m_lo = operand1;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", {31'b0, busy}, {31'b0, m_rem > 0});
            check("start", {31'b0, start},
                  {31'b0, operation >= 1 && operation <= 4 && m_rem == 0 && !cancel});
            check("result", result, operation == 5 ? m_hi : operation == 6 ? m_lo : 32'h0);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        @(posedge clk);
        #1;
        operation = op; operand1 = a; operand2 = b; cancel = c;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    task automatic count_busy(input string nm, input int exp);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(nm, n, exp);
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string nm);
        issue(op, '0, '0, 1'b0);
        @(negedge clk);
        check(nm, result, exp);
        check({nm, "_model"}, op == 5 ? m_hi : m_lo, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rd(5, 32'h0, "rst_hi");
        rd(6, 32'h0, "rst_lo");

        issue(1, 32'hFFFFFFFE, 32'h3, 1'b0);
        @(negedge clk);
        check("mult_start", {31'b0, start}, 32'h1);
        issue(0, '0, '0, 1'b0);
        count_busy("mult_cycles", MC);
        rd(5, 32'hFFFFFFFF, "mult_hi");
        rd(6, 32'hFFFFFFFA, "mult_lo");

        issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(0, '0, '0, 1'b0);
        wait_idle();
        rd(5, 32'hFFFFFFFE, "multu_hi");
        rd(6, 32'h00000001, "multu_lo");

        issue(3, 32'hFFFFFFF9, 32'h2, 1'b0);
        issue(0, '0, '0, 1'b0);
        count_busy("div_cycles", DC);
        rd(6, 32'hFFFFFFFD, "div_lo");
        rd(5, 32'hFFFFFFFF, "div_hi");

        issue(4, 32'h7, 32'h2, 1'b0);
        issue(0, '0, '0, 1'b0);
        wait_idle();
        rd(6, 32'h3, "divu_lo");
        rd(5, 32'h1, "divu_hi");

        issue(3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(0, '0, '0, 1'b0);
        wait_idle();
        rd(6, 32'h80000000, "divmin_lo");
        rd(5, 32'h0, "divmin_hi");

        issue(7, 32'h11, '0, 1'b0);
        issue(8, 32'h22, '0, 1'b0);
        issue(3, 32'h5, 32'h0, 1'b0);
        issue(0, '0, '0, 1'b0);
        count_busy("div0_cycles", DC);
        rd(5, 32'h11, "div0_hi");
        rd(6, 32'h22, "div0_lo");

        issue(1, 32'h3, 32'h4, 1'b0);
        issue(8, 32'h55, '0, 1'b0);
        issue(1, 32'd100, 32'd100, 1'b0);
        issue(0, '0, '0, 1'b0);
        count_busy("mult_noext", 3);
        rd(6, 32'd12, "busy_mtlo_lo");
        rd(5, 32'h0, "busy_mtlo_hi");

        issue(1, 32'h5, 32'h5, 1'b1);
        @(negedge clk);
        check("cancel_start", {31'b0, start}, 32'h0);
        issue(7, 32'h99, '0, 1'b1);
        issue(0, '0, '0, 1'b0);
        @(negedge clk);
        check("cancel_busy", {31'b0, busy}, 32'h0);
        rd(5, 32'h0, "cancel_hi");
        rd(6, 32'd12, "cancel_lo");

        issue(7, 32'hAA, '0, 1'b0);
        issue(3, 32'd100, 32'd7, 1'b0);
        issue(5, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_hi", result, 32'h0);
        operation = 6;
        #1;
        check("arst_lo", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("arst_late_busy", {31'b0, busy}, 32'h0);
        rd(6, 32'h0, "arst_late_lo");
        rd(5, 32'h0, "arst_late_hi");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 3) == 0 ? 32'(int'($urandom_range(0, 20)) - 10) : $urandom;
            b = $urandom_range(0, 5) == 0 ? 32'h0 :
                $urandom_range(0, 2) == 0 ? 32'(int'($urandom_range(0, 20)) - 10) : $urandom;
            issue(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 9) == 0);
        end
        issue(0, '0, '0, 1'b0);
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
